// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative multiply/divide unit that sits beside the ALU in the execute stage
// and owns the architectural HI/LO registers. It serves MULT, MULTU, DIV, DIVU
// (DATA_WIDTH iterations plus one sign-fix cycle) and MTHI/MTLO (single edge).
//
// Ports
//   i_clk       single clock, rising edge
//   i_rst       asynchronous, active-high reset
//   i_start     request, sampled only while idle
//   i_op        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   i_a         multiplicand / dividend / MTHI-MTLO source (rs)
//   i_b         multiplier / divisor (rt)
//   o_busy      iterative operation in flight
//   o_done      one-cycle pulse: o_hi/o_lo hold the new result
//   o_div_zero  DIV/DIVU had a zero divisor; held until the next accepted op
//   o_hi, o_lo  HI and LO registers
// -----------------------------------------------------------------------------
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [2:0]            i_op,
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_div_zero,
   output logic [DATA_WIDTH-1:0] o_hi,
   output logic [DATA_WIDTH-1:0] o_lo
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Two's-complement negation helpers for single and double width values.
   function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
      return (~v) + W'(1);
   endfunction

   function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
      return (~v) + (2*W)'(1);
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_div_zero;
   logic [W-1:0]      r_hi;
   logic [W-1:0]      r_lo;
   // r_acc: multiply = {partial product, remaining multiplier bits};
   //        divide   = {partial remainder, dividend bits / quotient bits}.
   logic [2*W-1:0]    r_acc;
   logic [W-1:0]      r_opb;      // multiplicand magnitude or divisor magnitude
   logic [W-1:0]      r_a_raw;    // original dividend, returned in HI on B=0
   logic              r_is_div;
   logic              r_b_zero;
   logic              r_neg_q;    // negate product / quotient
   logic              r_neg_r;    // negate remainder (sign of dividend)

   logic              w_idle;
   logic              w_accept_iter;
   logic              w_signed_op;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [W-1:0]      w_mag_a;
   logic [W-1:0]      w_mag_b;
   logic [W:0]        w_mul_sum;
   logic [2*W-1:0]    w_mul_next;
   logic [W:0]        w_div_shift;
   logic [W-1:0]      w_div_diff;
   logic              w_div_ge;
   logic [2*W-1:0]    w_div_next;
   logic [2*W-1:0]    w_prod;
   logic [W-1:0]      w_quot;
   logic [W-1:0]      w_rem;

   assign w_idle        = (r_state == ST_IDLE);
   assign w_accept_iter = w_idle && i_start && (i_op[2] == 1'b0);
   // MULT (000) and DIV (010) are the signed variants.
   assign w_signed_op   = (i_op[0] == 1'b0);
   assign w_a_neg       = w_signed_op && i_a[W-1];
   assign w_b_neg       = w_signed_op && i_b[W-1];
   assign w_mag_a       = w_a_neg ? neg_w(i_a) : i_a;
   assign w_mag_b       = w_b_neg ? neg_w(i_b) : i_b;

   // Radix-2 shift-add: add multiplicand when the current multiplier bit is 1,
   // then shift the whole accumulator right; the carry lands in the top bit.
   assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
   assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

   // Restoring divide: shift the next dividend bit into the remainder and
   // subtract the divisor when it fits. The difference always fits W bits.
   assign w_div_shift = r_acc[2*W-1:W-1];
   assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
   assign w_div_diff  = w_div_shift[W-1:0] - r_opb;
   assign w_div_next  = w_div_ge ? {w_div_diff, r_acc[W-2:0], 1'b1}
                                 : {w_div_shift[W-1:0], r_acc[W-2:0], 1'b0};

   // Sign correction applied in the FIX cycle. The DIV overflow case
   // (MIN / -1) falls out naturally: magnitude 2^(W-1) negates to itself.
   assign w_prod = r_neg_q ? neg_2w(r_acc) : r_acc;
   assign w_quot = r_neg_q ? neg_w(r_acc[W-1:0]) : r_acc[W-1:0];
   assign w_rem  = r_neg_r ? neg_w(r_acc[2*W-1:W]) : r_acc[2*W-1:W];

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept_iter) begin
               w_state_nxt = ST_CALC;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (r_cnt == CW'(W-1)) begin
               w_state_nxt = ST_FIX;
            end else begin
               w_state_nxt = ST_CALC;
            end
         end
         ST_FIX:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath, HI/LO and registered status outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_acc      <= '0;
         r_opb      <= '0;
         r_a_raw    <= '0;
         r_is_div   <= 1'b0;
         r_b_zero   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept_iter) begin
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_div_zero <= 1'b0;
                  r_is_div   <= i_op[1];
                  r_a_raw    <= i_a;
                  r_b_zero   <= (i_b == {W{1'b0}});
                  r_neg_q    <= w_a_neg ^ w_b_neg;
                  r_neg_r    <= w_a_neg;
                  if (i_op[1]) begin
                     r_acc <= {{W{1'b0}}, w_mag_a};
                     r_opb <= w_mag_b;
                  end else begin
                     r_acc <= {{W{1'b0}}, w_mag_b};
                     r_opb <= w_mag_a;
                  end
               end else if (i_start && (i_op == OP_MTHI)) begin
                  r_hi <= i_a;
               end else if (i_start && (i_op == OP_MTLO)) begin
                  r_lo <= i_a;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_CALC: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_is_div) begin
                  r_acc <= w_div_next;
               end else begin
                  r_acc <= w_mul_next;
               end
            end
            ST_FIX: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
               if (!r_is_div) begin
                  r_hi <= w_prod[2*W-1:W];
                  r_lo <= w_prod[W-1:0];
               end else if (r_b_zero) begin
                  r_hi       <= r_a_raw;
                  r_lo       <= {W{1'b1}};
                  r_div_zero <= 1'b1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_div_zero = r_div_zero;
   assign o_hi       = r_hi;
   assign o_lo       = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed self-checking bench for mul_div_unit. Inputs change #1 after a
// rising edge; outputs are sampled at the same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   int lat;
   int bcyc;

   mul_div_unit #(.DATA_WIDTH(32)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_op       (op),
      .i_a        (a),
      .i_b        (b),
      .o_busy     (busy),
      .o_done     (done),
      .o_div_zero (div_zero),
      .o_hi       (hi),
      .o_lo       (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge, then scramble operands to show they are
   // not re-sampled after the start edge.
   task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 3'b110;
      a     = 32'hA5A5_5A5A;
      b     = 32'h0F0F_F0F0;
   endtask

   // Count edges from the start edge until done; optionally inject an MTLO
   // request while busy at a given edge offset.
   task automatic wait_done(input int inj_at, output int n, output int nb);
      n  = 0;
      nb = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) nb++;
         if (n == inj_at) begin
            start = 1'b1;
            op    = 3'b101;
            a     = 32'h0000_DEAD;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp_hi,
                      input logic [31:0] exp_lo, input logic exp_dz);
      @(negedge clk);
      #1;
      launch(o, x, y);
      wait_done(-1, lat, bcyc);
      chk({tag, "_lat"},  32'(lat),  32'd33);
      chk({tag, "_busy"}, 32'(bcyc), 32'd33);
      chk({tag, "_hi"},   hi, exp_hi);
      chk({tag, "_lo"},   lo, exp_lo);
      chk({tag, "_dz"},   {31'd0, div_zero}, {31'd0, exp_dz});
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'b000;
      a     = 32'd0;
      b     = 32'd0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dz",   {31'd0, div_zero}, 32'd0);
      chk("rst_hi",   hi, 32'd0);
      chk("rst_lo",   lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);

      run("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run("mult_min",  3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run("divu_7_2",  3'b011, 32'd7,         32'd2,        32'd1,         32'd3,         1'b0);
      run("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
      run("divu_zero", 3'b011, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("dz_held", {31'd0, div_zero}, 32'd1);

      // div_zero must clear on the start edge of the next operation.
      @(negedge clk);
      #1;
      launch(3'b001, 32'd2, 32'd3);
      chk("dz_clear", {31'd0, div_zero}, 32'd0);
      wait_done(-1, lat, bcyc);
      chk("mul23_lat", 32'(lat), 32'd33);
      chk("mul23_hi",  hi, 32'd0);
      chk("mul23_lo",  lo, 32'd6);

      // MTHI while idle: immediate, no busy, no done.
      @(negedge clk);
      #1;
      start = 1'b1;
      op    = 3'b100;
      a     = 32'h1234_5678;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("mthi_hi",   hi, 32'h1234_5678);
      chk("mthi_lo",   lo, 32'd6);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      chk("mthi_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
      chk("mthi_done2", {31'd0, done}, 32'd0);

      // MTLO presented while busy must be ignored.
      @(negedge clk);
      #1;
      launch(3'b001, 32'd3, 32'd4);
      wait_done(4, lat, bcyc);
      chk("ign_lat", 32'(lat), 32'd33);
      chk("ign_hi",  hi, 32'd0);
      chk("ign_lo",  lo, 32'd12);
      @(posedge clk);
      #1;
      chk("ign_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      #1;
      launch(3'b011, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_hi",   hi, 32'd0);
      chk("arst_lo",   lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

      // Back-to-back: new start on the done cycle.
      @(negedge clk);
      #1;
      launch(3'b001, 32'h0001_0000, 32'h0001_0000);
      wait_done(-1, lat, bcyc);
      chk("b2b1_lat", 32'(lat), 32'd33);
      chk("b2b1_hi",  hi, 32'd1);
      chk("b2b1_lo",  lo, 32'd0);
      launch(3'b001, 32'h0000_FFFF, 32'h0001_0001);
      chk("b2b2_busy", {31'd0, busy}, 32'd1);
      chk("b2b2_done", {31'd0, done}, 32'd0);
      wait_done(-1, lat, bcyc);
      chk("b2b2_lat", 32'(lat), 32'd33);
      chk("b2b2_hi",  hi, 32'd0);
      chk("b2b2_lo",  lo, 32'hFFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
